// File: rtl/matrix_scan_driver_if.sv
// Signal bundle between the matrix scan driver, the game framebuffer and the
// LED matrix pad outputs. The master side is the scan driver.
interface matrix_scan_driver_if;
    logic [3:0]  row_addr;
    logic [15:0] row_data;
    logic        frame_start;
    logic        RCLK;
    logic        RSDI;
    logic        CCLK;
    logic        CSDI;
    logic        LE;
    logic        OEB;

    modport master (
        output row_addr,
        input  row_data,
        output frame_start,
        output RCLK,
        output RSDI,
        output CCLK,
        output CSDI,
        output LE,
        output OEB
    );

    modport slave (
        input  row_addr,
        output row_data,
        input  frame_start,
        input  RCLK,
        input  RSDI,
        input  CCLK,
        input  CSDI,
        input  LE,
        input  OEB
    );
endinterface

// File: rtl/matrix_scan_driver.sv
// Row-scanning driver for a 16x16 LED matrix: fetches a framebuffer row, shifts
// it into the column chain, walks a one-hot token down the row chain, latches, holds.
module matrix_scan_driver #(
    parameter int CLKDIV = 2,
    parameter int HOLD   = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_scan_driver_if.master bus
);

    localparam int CNT_MAX = (2 * CLKDIV > HOLD) ? 2 * CLKDIV : HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SLOT_LAST  = CW'(2 * CLKDIV - 1);
    localparam logic [CW-1:0] HALF_SLOT  = CW'(CLKDIV);
    localparam logic [CW-1:0] LATCH_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    state_t        state_q, state_d;
    logic          primed_q, primed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    slot_q, slot_d;
    logic [3:0]    row_q, row_d;
    logic [15:0]   col_sr_q, col_sr_d;

    logic          frame_start_q, frame_start_d;
    logic          rclk_q, rclk_d;
    logic          rsdi_q, rsdi_d;
    logic          cclk_q, cclk_d;
    logic          csdi_q, csdi_d;
    logic          le_q, le_d;
    logic          oeb_q, oeb_d;

    logic          shift_next;

    // The reset state is LOAD with all outputs idle; primed_q spends one cycle
    // there so that the real row-0 LOAD cycle shows frame_start.
    always_comb begin
        state_d  = state_q;
        primed_d = primed_q;
        cnt_d    = cnt_q;
        slot_d   = slot_q;
        row_d    = row_q;
        col_sr_d = col_sr_q;

        case (state_q)
            ST_LOAD: begin
                if (!primed_q) begin
                    primed_d = 1'b1;
                end else begin
                    col_sr_d = bus.row_data;
                    cnt_d    = '0;
                    slot_d   = 4'd0;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d    = '0;
                    col_sr_d = {col_sr_q[14:0], 1'b0};
                    if (slot_q == 4'd15) begin
                        slot_d  = 4'd0;
                        state_d = ST_LATCH;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DISPLAY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DISPLAY: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    row_d   = row_q + 4'd1;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Outputs are decoded from the next-cycle state so every pad is a flop
    // that already shows the correct level during the cycle it belongs to.
    always_comb begin
        shift_next    = (state_d == ST_SHIFT);
        frame_start_d = (state_d == ST_LOAD) && (row_d == 4'd0);
        cclk_d        = shift_next && (cnt_d >= HALF_SLOT);
        csdi_d        = shift_next && col_sr_d[15];
        rclk_d        = cclk_d && (slot_d == 4'd0);
        rsdi_d        = shift_next && (slot_d == 4'd0) && (row_d == 4'd0);
        le_d          = (state_d == ST_LATCH);
        oeb_d         = oeb_q;
        if (state_d == ST_LATCH) begin
            oeb_d = 1'b1;
        end else if (state_d == ST_DISPLAY) begin
            oeb_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            primed_q      <= 1'b0;
            cnt_q         <= '0;
            slot_q        <= 4'd0;
            row_q         <= 4'd0;
            col_sr_q      <= 16'd0;
            frame_start_q <= 1'b0;
            rclk_q        <= 1'b0;
            rsdi_q        <= 1'b0;
            cclk_q        <= 1'b0;
            csdi_q        <= 1'b0;
            le_q          <= 1'b0;
            oeb_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            primed_q      <= primed_d;
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            row_q         <= row_d;
            col_sr_q      <= col_sr_d;
            frame_start_q <= frame_start_d;
            rclk_q        <= rclk_d;
            rsdi_q        <= rsdi_d;
            cclk_q        <= cclk_d;
            csdi_q        <= csdi_d;
            le_q          <= le_d;
            oeb_q         <= oeb_d;
        end
    end

    assign bus.row_addr    = row_q;
    assign bus.frame_start = frame_start_q;
    assign bus.RCLK        = rclk_q;
    assign bus.RSDI        = rsdi_q;
    assign bus.CCLK        = cclk_q;
    assign bus.CSDI        = csdi_q;
    assign bus.LE          = le_q;
    assign bus.OEB         = oeb_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Checks two driver instances (default timing and CLKDIV=1/HOLD=4) cycle by cycle
// against a timeline model of the scan row, plus edge/period event checks.
module tb_matrix_scan_driver;

    localparam int DV [2] = '{2, 1};
    localparam int HV [2] = '{256, 4};

    logic        clk;
    logic        reset;
    logic [15:0] fb [16];
    logic [15:0] mask;
    logic        flip_en;

    matrix_scan_driver_if if0 ();
    matrix_scan_driver_if if1 ();

    assign if0.row_data = fb[if0.row_addr] ^ mask;
    assign if1.row_data = fb[if1.row_addr] ^ mask;

    matrix_scan_driver #(.CLKDIV(2), .HOLD(256)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    matrix_scan_driver #(.CLKDIV(1), .HOLD(4))   dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed vector: {frame_start, RCLK, RSDI, CCLK, CSDI, LE, OEB}
    logic [6:0] obs0, obs1;
    assign obs0 = {if0.frame_start, if0.RCLK, if0.RSDI, if0.CCLK, if0.CSDI, if0.LE, if0.OEB};
    assign obs1 = {if1.frame_start, if1.RCLK, if1.RSDI, if1.CCLK, if1.CSDI, if1.LE, if1.OEB};

    int checks;
    int errors;
    int cyc;

    // model state per instance
    int          t_m     [2];
    int          r_m     [2];
    bit          shown_m [2];
    logic [15:0] ld_m    [2];
    int          ccnt    [2];
    int          rcnt    [2];
    int          lecnt   [2];
    int          olcnt   [2];
    logic [15:0] bits    [2];
    logic        rs_rise [2];
    logic        pc      [2];
    logic        pr      [2];
    int          last_fs [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp_v);
        end
    endtask

    // Expected pad levels at cycle t of a row (t=0 is LOAD), from the row timeline.
    function automatic logic [6:0] expect_out(input int d, input int t, input int r,
                                              input bit shown, input logic [15:0] data);
        int   sh_end;
        int   lat_end;
        int   s;
        int   ph;
        logic fs, rclk, rsdi, cclk, csdi, le, oeb;
        sh_end  = 1 + 32 * d;
        lat_end = sh_end + d;
        fs   = (t == 0) && (r == 0);
        rclk = 1'b0;
        rsdi = 1'b0;
        cclk = 1'b0;
        csdi = 1'b0;
        le   = 1'b0;
        oeb  = !shown;
        if (t >= 1 && t < sh_end) begin
            s    = (t - 1) / (2 * d);
            ph   = (t - 1) % (2 * d);
            cclk = (ph >= d);
            csdi = data[15 - s];
            rsdi = (s == 0) && (r == 0);
            rclk = (s == 0) && cclk;
        end else if (t >= sh_end && t < lat_end) begin
            le  = 1'b1;
            oeb = 1'b1;
        end else if (t >= lat_end) begin
            oeb = 1'b0;
        end
        return {fs, rclk, rsdi, cclk, csdi, le, oeb};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            t_m[k]     = 0;
            r_m[k]     = 0;
            shown_m[k] = 1'b0;
            ld_m[k]    = 16'd0;
            ccnt[k]    = 0;
            rcnt[k]    = 0;
            lecnt[k]   = 0;
            olcnt[k]   = 0;
            bits[k]    = 16'd0;
            rs_rise[k] = 1'b0;
            pc[k]      = 1'b0;
            pr[k]      = 1'b0;
            last_fs[k] = -1;
        end
    endtask

    task automatic check_dut(input int k);
        int         d;
        int         h;
        int         per;
        int         sh_end;
        logic [6:0] o;
        logic [6:0] e;
        logic [3:0] ra;
        d      = DV[k];
        h      = HV[k];
        per    = 1 + 33 * d + h;
        sh_end = 1 + 32 * d;
        o      = (k == 0) ? obs0 : obs1;
        ra     = (k == 0) ? if0.row_addr : if1.row_addr;
        e      = expect_out(d, t_m[k], r_m[k], shown_m[k], ld_m[k]);

        chk("frame_start", k, 32'(o[6]), 32'(e[6]));
        chk("RCLK",        k, 32'(o[5]), 32'(e[5]));
        chk("CCLK",        k, 32'(o[3]), 32'(e[3]));
        chk("LE",          k, 32'(o[1]), 32'(e[1]));
        chk("OEB",         k, 32'(o[0]), 32'(e[0]));
        chk("row_addr",    k, 32'(ra),   32'(r_m[k]));
        if (t_m[k] >= 1 && t_m[k] < sh_end) begin
            chk("CSDI", k, 32'(o[2]), 32'(e[2]));
            chk("RSDI", k, 32'(o[4]), 32'(e[4]));
        end

        if (o[3] && !pc[k]) begin
            ccnt[k]++;
            bits[k] = {bits[k][14:0], o[2]};
        end
        if (o[5] && !pr[k]) begin
            rcnt[k]++;
            rs_rise[k] = o[4];
        end
        if (o[1]) lecnt[k]++;
        if (t_m[k] >= sh_end && !o[0]) olcnt[k]++;
        if (o[6]) begin
            if (last_fs[k] >= 0) chk("frame_period", k, 32'(cyc - last_fs[k]), 32'(16 * per));
            last_fs[k] = cyc;
        end
        pc[k] = o[3];
        pr[k] = o[5];
        if (t_m[k] >= sh_end + d) shown_m[k] = 1'b1;

        if (t_m[k] == per - 1) begin
            chk("cclk_rises",   k, 32'(ccnt[k]),   32'd16);
            chk("rclk_rises",   k, 32'(rcnt[k]),   32'd1);
            chk("shifted_row",  k, 32'(bits[k]),   32'(ld_m[k]));
            chk("rsdi_at_rclk", k, 32'(rs_rise[k]), 32'(r_m[k] == 0));
            chk("le_width",     k, 32'(lecnt[k]),  32'(d));
            chk("oeb_low",      k, 32'(olcnt[k]),  32'(h));
        end
    endtask

    task automatic advance(input int k);
        int per;
        per = 1 + 33 * DV[k] + HV[k];
        t_m[k]++;
        if (t_m[k] == per) begin
            t_m[k]     = 0;
            r_m[k]     = (r_m[k] + 1) % 16;
            ccnt[k]    = 0;
            rcnt[k]    = 0;
            lecnt[k]   = 0;
            olcnt[k]   = 0;
            bits[k]    = 16'd0;
            rs_rise[k] = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) check_dut(k);
            if (flip_en) mask = ~mask;
            // the value on row_data from now until the next edge is what LOAD captures
            for (int k = 0; k < 2; k++) begin
                if (t_m[k] == 0) ld_m[k] = fb[r_m[k]] ^ mask;
            end
            for (int k = 0; k < 2; k++) advance(k);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pads0"}, 0, 32'(obs0), 32'(7'b0000001));
        chk({tag, "_row0"},  0, 32'(if0.row_addr), 32'd0);
        chk({tag, "_pads1"}, 1, 32'(obs1), 32'(7'b0000001));
        chk({tag, "_row1"},  1, 32'(if1.row_addr), 32'd0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        reset   = 1'b1;
        mask    = 16'd0;
        flip_en = 1'b0;
        for (int i = 0; i < 16; i++) fb[i] = 16'($urandom);
        fb[0] = 16'hA5C3;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        model_reset();

        // into row 1 SHIFT of the default instance, then reset asynchronously
        run(340);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async");
        @(negedge clk);
        check_reset_outputs("held");
        reset = 1'b0;
        model_reset();

        // more than one full default frame with fixed framebuffer contents
        run(5300);

        // row_data toggling every cycle; only LOAD-time values may be shifted
        flip_en = 1'b1;
        run(700);
        flip_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
